// File: rtl/wb_byte_bridge.sv
// 32-bit Wishbone classic slave to 8-bit Wishbone classic master bridge, big-endian lanes.
// Define WB_BYTE_BRIDGE_TIMEOUT_EN to abort downstream transactions after TIMEOUT cycles.
module wb_byte_bridge #(
   parameter int DEBUG   = 0,
   parameter int TIMEOUT = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_we_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic [2:0]  wbs_cti_i,
   input  logic [1:0]  wbs_bte_i,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_ack_o,
   output logic        wbs_err_o,
   output logic        wbs_rty_o,
   output logic [31:0] wbm_adr_o,
   output logic [7:0]  wbm_dat_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic [2:0]  wbm_cti_o,
   output logic [1:0]  wbm_bte_o,
   input  logic [7:0]  wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   input  logic        wbm_rty_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_GAP, S_DONE, S_FAIL_ERR, S_FAIL_RTY
   } state_t;

   state_t      state_q, state_d;
   logic [29:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic        we_q, we_d;
   logic [3:0]  lanes_q, lanes_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rbuf_q, rbuf_d;

   logic [31:0] wbs_dat_q, wbs_dat_d;
   logic        wbs_ack_q, wbs_ack_d;
   logic        wbs_err_q, wbs_err_d;
   logic        wbs_rty_q, wbs_rty_d;
   logic [31:0] wbm_adr_q, wbm_adr_d;
   logic [7:0]  wbm_dat_q, wbm_dat_d;
   logic        wbm_we_q, wbm_we_d;
   logic        wbm_cyc_q, wbm_cyc_d;

   logic        start;
   logic [29:0] src_adr;
   logic [31:0] src_dat;
   logic        src_we;
   logic [3:0]  src_lanes;
   logic [1:0]  lane_sh;

`ifdef WB_BYTE_BRIDGE_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   // Lowest byte offset first: sel[3] is offset 0.
   function automatic logic [1:0] first_off(input logic [3:0] l);
      if (l[3])      return 2'd0;
      else if (l[2]) return 2'd1;
      else if (l[1]) return 2'd2;
      else           return 2'd3;
   endfunction

   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      we_d      = we_q;
      lanes_d   = lanes_q;
      off_d     = off_q;
      rbuf_d    = rbuf_q;
      wbs_dat_d = '0;
      wbs_ack_d = 1'b0;
      wbs_err_d = 1'b0;
      wbs_rty_d = 1'b0;
      wbm_adr_d = wbm_adr_q;
      wbm_dat_d = wbm_dat_q;
      wbm_we_d  = wbm_we_q;
      wbm_cyc_d = 1'b0;
      start     = 1'b0;
      src_adr   = adr_q;
      src_dat   = dat_q;
      src_we    = we_q;
      src_lanes = lanes_q;
      lane_sh   = ~off_q;
`ifdef WB_BYTE_BRIDGE_TIMEOUT_EN
      tmo_d     = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               adr_d   = wbs_adr_i[31:2];
               dat_d   = wbs_dat_i;
               we_d    = wbs_we_i;
               lanes_d = wbs_sel_i;
               rbuf_d  = '0;
               if (wbs_sel_i == 4'b0000) begin
                  state_d   = S_DONE;
                  wbs_ack_d = 1'b1;
               end else begin
                  start     = 1'b1;
                  src_adr   = wbs_adr_i[31:2];
                  src_dat   = wbs_dat_i;
                  src_we    = wbs_we_i;
                  src_lanes = wbs_sel_i;
               end
            end
         end
         S_ISSUE: begin
            if (!wbs_cyc_i) begin
               state_d = S_IDLE;
            end else if (wbm_err_i) begin
               state_d   = S_FAIL_ERR;
               wbs_err_d = 1'b1;
            end else if (wbm_rty_i) begin
               state_d   = S_FAIL_RTY;
               wbs_rty_d = 1'b1;
            end else if (wbm_ack_i) begin
               rbuf_d[{lane_sh, 3'b000} +: 8] = wbm_dat_i;
               lanes_d[lane_sh] = 1'b0;
               if (lanes_d == 4'b0000) begin
                  state_d   = S_DONE;
                  wbs_ack_d = 1'b1;
                  wbs_dat_d = rbuf_d;
               end else begin
                  state_d = S_GAP;
               end
            end else begin
`ifdef WB_BYTE_BRIDGE_TIMEOUT_EN
               if (tmo_q == TW'(TIMEOUT - 1)) begin
                  state_d   = S_FAIL_ERR;
                  wbs_err_d = 1'b1;
               end else begin
                  tmo_d     = tmo_q + 1'b1;
                  wbm_cyc_d = 1'b1;
               end
`else
               wbm_cyc_d = 1'b1;
`endif
            end
         end
         S_GAP: begin
            if (!wbs_cyc_i) state_d = S_IDLE;
            else            start   = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         state_d   = S_ISSUE;
         off_d     = first_off(src_lanes);
         wbm_cyc_d = 1'b1;
         wbm_adr_d = {src_adr, off_d};
         wbm_dat_d = src_dat[{~off_d, 3'b000} +: 8];
         wbm_we_d  = src_we;
`ifdef WB_BYTE_BRIDGE_TIMEOUT_EN
         tmo_d     = '0;
`endif
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= S_IDLE;
         adr_q     <= '0;
         dat_q     <= '0;
         we_q      <= 1'b0;
         lanes_q   <= '0;
         off_q     <= '0;
         rbuf_q    <= '0;
         wbs_dat_q <= '0;
         wbs_ack_q <= 1'b0;
         wbs_err_q <= 1'b0;
         wbs_rty_q <= 1'b0;
         wbm_adr_q <= '0;
         wbm_dat_q <= '0;
         wbm_we_q  <= 1'b0;
         wbm_cyc_q <= 1'b0;
`ifdef WB_BYTE_BRIDGE_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         we_q      <= we_d;
         lanes_q   <= lanes_d;
         off_q     <= off_d;
         rbuf_q    <= rbuf_d;
         wbs_dat_q <= wbs_dat_d;
         wbs_ack_q <= wbs_ack_d;
         wbs_err_q <= wbs_err_d;
         wbs_rty_q <= wbs_rty_d;
         wbm_adr_q <= wbm_adr_d;
         wbm_dat_q <= wbm_dat_d;
         wbm_we_q  <= wbm_we_d;
         wbm_cyc_q <= wbm_cyc_d;
`ifdef WB_BYTE_BRIDGE_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign wbs_dat_o = wbs_dat_q;
   assign wbs_ack_o = wbs_ack_q;
   assign wbs_err_o = wbs_err_q;
   assign wbs_rty_o = wbs_rty_q;
   assign wbm_adr_o = wbm_adr_q;
   assign wbm_dat_o = wbm_dat_q;
   assign wbm_we_o  = wbm_we_q;
   assign wbm_cyc_o = wbm_cyc_q;
   assign wbm_stb_o = wbm_cyc_q;
   assign wbm_cti_o = 3'b000;
   assign wbm_bte_o = 2'b00;

   // Burst hints, address byte bits and DEBUG never reach the datapath.
   logic unused_ok;
   assign unused_ok = (^{wbs_cti_i, wbs_bte_i, wbs_adr_i[1:0]}) ^ (DEBUG != 0) ^ (TIMEOUT != 0);

endmodule

// File: tb/tb_wb_byte_bridge.sv
// Bench for wb_byte_bridge: byte-memory responder, table vectors, corner sequences, random vs model.
module tb_wb_byte_bridge;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic [3:0]  wbs_sel_i;
   logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
   logic [2:0]  wbs_cti_i;
   logic [1:0]  wbs_bte_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
   logic [31:0] wbm_adr_o;
   logic [7:0]  wbm_dat_o;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
   logic [2:0]  wbm_cti_o;
   logic [1:0]  wbm_bte_o;
   logic [7:0]  wbm_dat_i;
   logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_byte_bridge dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
      .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
      .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
      .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_we_o(wbm_we_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i)
   );

   function automatic logic [7:0] pat(input logic [7:0] a);
      return a ^ 8'h3C;
   endfunction

   // Downstream byte slave: answers after cfg_wait wait cycles, logs every answered transaction.
   localparam int LOGN = 1024;
   int          cfg_wait, cfg_err_at, cfg_rty_at;
   bit          cfg_hang;
   int          wcnt, txn_cnt;
   logic [31:0] log_adr [0:LOGN-1];
   logic [7:0]  log_dat [0:LOGN-1];
   logic        log_we  [0:LOGN-1];
   logic [7:0]  smem    [0:255];
   bit          svalid  [0:255];

   always @(negedge wb_clk_i) begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_rty_i = 1'b0;
      wbm_dat_i = 8'h00;
      if (wbm_cyc_o && wbm_stb_o && !cfg_hang && !wb_rst_i) begin
         if (wcnt < cfg_wait) begin
            wcnt++;
         end else begin
            wcnt = 0;
            if (txn_cnt < LOGN) begin
               log_adr[txn_cnt] = wbm_adr_o;
               log_dat[txn_cnt] = wbm_dat_o;
               log_we[txn_cnt]  = wbm_we_o;
            end
            if (txn_cnt == cfg_err_at)      wbm_err_i = 1'b1;
            else if (txn_cnt == cfg_rty_at) wbm_rty_i = 1'b1;
            else begin
               wbm_ack_i = 1'b1;
               if (wbm_we_o) begin
                  smem[wbm_adr_o[7:0]]   = wbm_dat_o;
                  svalid[wbm_adr_o[7:0]] = 1'b1;
               end else begin
                  wbm_dat_i = svalid[wbm_adr_o[7:0]] ? smem[wbm_adr_o[7:0]] : pat(wbm_adr_o[7:0]);
               end
            end
            txn_cnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   int checks, errors;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference memory: what a byte-addressed big-endian bus must end up holding.
   logic [7:0] mmem   [0:255];
   bit         mvalid [0:255];

   task automatic model(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, output logic [31:0] exp_rd);
      logic [7:0] a;
      exp_rd = '0;
      for (int off = 0; off < 4; off++) begin
         if (sel[3-off]) begin
            a = {adr[7:2], 2'(off)};
            if (we) begin
               mmem[a]   = dat[8*(3-off) +: 8];
               mvalid[a] = 1'b1;
            end else begin
               exp_rd[8*(3-off) +: 8] = mvalid[a] ? mmem[a] : pat(a);
            end
         end
      end
   endtask

   // resp: {rty,err,ack} at the first response cycle, 0 if none within budget.
   task automatic do_access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic we, output int resp, output int lat,
                            output logic [31:0] rdata, output int after);
      @(negedge wb_clk_i);
      wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
      wbs_cti_i = 3'($urandom_range(0, 7)); wbs_bte_i = 2'($urandom_range(0, 3));
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      resp = 0; lat = 0; rdata = '0;
      @(posedge wb_clk_i); #1;
      for (int n = 1; n <= 200; n++) begin
         if (wbs_ack_o || wbs_err_o || wbs_rty_o) begin
            resp  = int'({wbs_rty_o, wbs_err_o, wbs_ack_o});
            lat   = n;
            rdata = wbs_dat_o;
            break;
         end
         @(posedge wb_clk_i); #1;
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(posedge wb_clk_i); #1;
      after = int'({wbs_rty_o, wbs_err_o, wbs_ack_o});
   endtask

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
      int          nb;
      int          lat;
      logic [31:0] b0_adr;
      logic [7:0]  b0_dat;
      logic [31:0] rdata;
   } vec_t;

   vec_t        vt [8];
   int          resp, lat, after, base, n, w, k;
   logic [31:0] rdata, exp_rd, r_adr, r_dat;
   logic [3:0]  r_sel;
   logic        r_we;
   logic [5:0]  pat6;
   logic        seen;

   initial begin
      cfg_wait = 0; cfg_err_at = -1; cfg_rty_at = -1; cfg_hang = 1'b0;
      checks = 0; errors = 0;
      wb_rst_i = 1'b1;
      wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_we_i = 1'b0;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_cti_i = '0; wbs_bte_i = '0;

      vt[0] = '{32'h9000_0000, 32'h41FF_FFFF, 4'b1000, 1'b1, 1, 2, 32'h9000_0000, 8'h41, 32'h0};
      vt[1] = '{32'h9000_0004, 32'h1234_5A78, 4'b0010, 1'b1, 1, 2, 32'h9000_0006, 8'h5A, 32'h0};
      vt[2] = '{32'h9000_0004, 32'h0,         4'b0010, 1'b0, 1, 2, 32'h9000_0006, 8'h00, 32'h0000_5A00};
      vt[3] = '{32'h9000_0010, 32'h1122_3344, 4'b1111, 1'b1, 4, 8, 32'h9000_0010, 8'h11, 32'h0};
      vt[4] = '{32'h9000_0010, 32'h0,         4'b1111, 1'b0, 4, 8, 32'h9000_0010, 8'h00, 32'h1122_3344};
      vt[5] = '{32'h9000_0020, 32'h0,         4'b0000, 1'b0, 0, 1, 32'h0,         8'h00, 32'h0};
      vt[6] = '{32'h9000_0010, 32'h0,         4'b0101, 1'b0, 2, 4, 32'h9000_0011, 8'h00, 32'h0022_0044};
      vt[7] = '{32'h9000_0033, 32'hAABB_CCDD, 4'b0001, 1'b1, 1, 2, 32'h9000_0033, 8'hDD, 32'h0};

      repeat (3) @(posedge wb_clk_i);
      #1;
      chk("reset_outputs", {wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o, wbm_adr_o, wbm_dat_o,
                            wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o}, '0);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;

      for (int i = 0; i < 8; i++) begin
         base = txn_cnt;
         model(vt[i].adr, vt[i].dat, vt[i].sel, vt[i].we, exp_rd);
         do_access(vt[i].adr, vt[i].dat, vt[i].sel, vt[i].we, resp, lat, rdata, after);
         chk($sformatf("vec%0d_resp", i), resp, 1);
         chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
         chk($sformatf("vec%0d_single_pulse", i), after, 0);
         chk($sformatf("vec%0d_nbytes", i), txn_cnt - base, vt[i].nb);
         if (vt[i].nb > 0) chk($sformatf("vec%0d_b0_adr", i), log_adr[base], vt[i].b0_adr);
         if (vt[i].nb > 0 && vt[i].we) chk($sformatf("vec%0d_b0_dat", i), log_dat[base], vt[i].b0_dat);
         if (!vt[i].we) chk($sformatf("vec%0d_rdata", i), rdata, vt[i].rdata);
      end

      // Error on the second byte of a word read: offsets 2 and 3 must never go out.
      base = txn_cnt; cfg_err_at = base + 1;
      do_access(32'h9000_0010, 32'h0, 4'b1111, 1'b0, resp, lat, rdata, after);
      repeat (3) @(posedge wb_clk_i);
      #1;
      chk("err_resp", resp, 2);
      chk("err_lat", lat, 4);
      chk("err_single_pulse", after, 0);
      chk("err_nbytes", txn_cnt - base, 2);
      chk("err_b1_adr", log_adr[base+1], 32'h9000_0011);
      cfg_err_at = -1;

      base = txn_cnt; cfg_rty_at = base;
      do_access(32'h9000_0010, 32'h0, 4'b0100, 1'b0, resp, lat, rdata, after);
      chk("rty_resp", resp, 4);
      chk("rty_lat", lat, 2);
      chk("rty_nbytes", txn_cnt - base, 1);
      cfg_rty_at = -1;

      // Reset while a byte transaction is outstanding.
      cfg_hang = 1'b1;
      @(negedge wb_clk_i);
      wbs_adr_i = 32'h9000_0010; wbs_sel_i = 4'b1111; wbs_we_i = 1'b0;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      repeat (3) @(posedge wb_clk_i);
      #1;
      chk("hang_issue_cyc", {wbm_cyc_o, wbm_stb_o}, 2'b11);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i); #1;
      chk("midrst_outputs", {wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o, wbm_adr_o, wbm_dat_o,
                             wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o}, '0);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; cfg_hang = 1'b0;
      do_access(32'h9000_0010, 32'h0, 4'b1111, 1'b0, resp, lat, rdata, after);
      chk("postrst_resp", resp, 1);
      chk("postrst_rdata", rdata, 32'h1122_3344);

      // Master drops cyc while the bridge waits downstream.
      cfg_hang = 1'b1;
      @(negedge wb_clk_i);
      wbs_adr_i = 32'h9000_0010; wbs_sel_i = 4'b1100; wbs_we_i = 1'b0;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      repeat (2) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(posedge wb_clk_i); #1;
      chk("abort_drop", {wbm_cyc_o, wbm_stb_o}, 2'b00);
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         seen = seen | wbs_ack_o | wbs_err_o | wbs_rty_o;
         @(posedge wb_clk_i); #1;
      end
      chk("abort_no_resp", seen, 1'b0);
      cfg_hang = 1'b0;

      // Request held after DONE: accepted again, acked once per access.
      base = txn_cnt;
      model(32'h9000_0040, 32'h7700_0000, 4'b1000, 1'b1, exp_rd);
      @(negedge wb_clk_i);
      wbs_adr_i = 32'h9000_0040; wbs_dat_i = 32'h7700_0000; wbs_sel_i = 4'b1000; wbs_we_i = 1'b1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      pat6 = '0;
      @(posedge wb_clk_i); #1;
      for (int c = 1; c <= 6; c++) begin
         pat6[c-1] = wbs_ack_o;
         if (c < 6) begin
            @(posedge wb_clk_i); #1;
         end
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      repeat (3) @(posedge wb_clk_i);
      #1;
      chk("b2b_ack_pattern", pat6, 6'b010010);
      chk("b2b_nbytes", txn_cnt - base, 2);

      // Random accesses against the reference memory.
      for (int i = 0; i < 40; i++) begin
         r_adr = {24'h900000, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
         r_dat = $urandom;
         r_sel = 4'($urandom_range(0, 15));
         r_we  = 1'($urandom_range(0, 1));
         w     = $urandom_range(0, 2);
         cfg_wait = w;
         base  = txn_cnt;
         n     = $countones(r_sel);
         model(r_adr, r_dat, r_sel, r_we, exp_rd);
         do_access(r_adr, r_dat, r_sel, r_we, resp, lat, rdata, after);
         chk($sformatf("rnd%0d_resp", i), resp, 1);
         chk($sformatf("rnd%0d_lat", i), lat, (n == 0) ? 1 : n * (2 + w));
         chk($sformatf("rnd%0d_nbytes", i), txn_cnt - base, n);
         k = 0;
         for (int off = 0; off < 4; off++) begin
            if (r_sel[3-off] && k < n) begin
               chk($sformatf("rnd%0d_adr%0d", i, k), {log_we[base+k], log_adr[base+k]},
                   {r_we, r_adr[31:2], 2'(off)});
               if (r_we) chk($sformatf("rnd%0d_dat%0d", i, k), log_dat[base+k], r_dat[8*(3-off) +: 8]);
               k++;
            end
         end
         if (!r_we) chk($sformatf("rnd%0d_rdata", i), rdata, exp_rd);
      end
      cfg_wait = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
